raster_checker: RTL and testbench

RASTER_CHECKER -- requirements
Module: raster_checker

---
 rtl/raster_checker.sv | 134 +++++++++++++
 tb/tb_raster_checker.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/raster_checker.sv
// raster_checker: tracks a 16x16 raster scan, reports addresses, frame boundaries and scan-order errors.
// Optional error counter output err_count is enabled by defining RASTER_CHECKER_ERRCNT_EN.
`default_nettype none

module raster_checker (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [7:0] addr,
  output logic       addr_valid,
  output logic       frame_start,
  output logic       frame_done,
  output logic       err,
  output logic       locked,
  output logic [7:0] frame_count
`ifdef RASTER_CHECKER_ERRCNT_EN
  ,
  output logic [7:0] err_count
`endif
);

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    TRACK = 2'd1,
    ERROR = 2'd2
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [7:0] r_exp, w_exp_nxt;
  logic [7:0] r_addr, w_addr_nxt;
  logic [7:0] r_frame_count, w_frame_count_nxt;
  logic       r_addr_valid, w_addr_valid_nxt;
  logic       r_frame_start, w_frame_start_nxt;
  logic       r_frame_done, w_frame_done_nxt;
  logic       r_err, w_err_nxt;
  logic       r_locked;
  logic [7:0] w_pos;
  logic       w_origin;

  assign w_pos    = {y, x};
  assign w_origin = (w_pos == 8'd0);

  always_comb begin
    w_state_nxt       = r_state;
    w_exp_nxt         = r_exp;
    w_addr_nxt        = r_addr;
    w_frame_count_nxt = r_frame_count;
    w_addr_valid_nxt  = 1'b0;
    w_frame_start_nxt = 1'b0;
    w_frame_done_nxt  = 1'b0;
    w_err_nxt         = 1'b0;
    if (in_valid) begin
      case (r_state)
        SYNC, ERROR: begin
          // Only the frame origin can (re)establish lock; anything else is silently dropped.
          if (w_origin) begin
            w_state_nxt       = TRACK;
            w_exp_nxt         = 8'd1;
            w_addr_nxt        = 8'd0;
            w_addr_valid_nxt  = 1'b1;
            w_frame_start_nxt = 1'b1;
          end
        end
        TRACK: begin
          if (w_pos == r_exp) begin
            w_addr_nxt        = w_pos;
            w_addr_valid_nxt  = 1'b1;
            w_exp_nxt         = r_exp + 8'd1;
            w_frame_start_nxt = w_origin;
            if (w_pos == 8'hFF) begin
              w_frame_done_nxt  = 1'b1;
              w_frame_count_nxt = r_frame_count + 8'd1;
            end
          end else begin
            w_err_nxt   = 1'b1;
            w_state_nxt = ERROR;
          end
        end
        default: w_state_nxt = SYNC;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= SYNC;
      r_exp         <= 8'd0;
      r_addr        <= 8'd0;
      r_frame_count <= 8'd0;
      r_addr_valid  <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_done  <= 1'b0;
      r_err         <= 1'b0;
      r_locked      <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_exp         <= w_exp_nxt;
      r_addr        <= w_addr_nxt;
      r_frame_count <= w_frame_count_nxt;
      r_addr_valid  <= w_addr_valid_nxt;
      r_frame_start <= w_frame_start_nxt;
      r_frame_done  <= w_frame_done_nxt;
      r_err         <= w_err_nxt;
      r_locked      <= (w_state_nxt == TRACK);
    end
  end

  assign addr        = r_addr;
  assign addr_valid  = r_addr_valid;
  assign frame_start = r_frame_start;
  assign frame_done  = r_frame_done;
  assign err         = r_err;
  assign locked      = r_locked;
  assign frame_count = r_frame_count;

`ifdef RASTER_CHECKER_ERRCNT_EN
  logic [7:0] r_err_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err_count <= 8'd0;
    end else if (w_err_nxt && (r_err_count != 8'hFF)) begin
      r_err_count <= r_err_count + 8'd1;
    end
  end

  assign err_count = r_err_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_raster_checker.sv
// Randomized self-checking bench for raster_checker against a scan-position reference model.
`default_nettype none

module tb_raster_checker;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [3:0] x;
  logic [3:0] y;
  logic [7:0] addr;
  logic       addr_valid;
  logic       frame_start;
  logic       frame_done;
  logic       err;
  logic       locked;
  logic [7:0] frame_count;
`ifdef RASTER_CHECKER_ERRCNT_EN
  logic [7:0] err_count;
`endif

  raster_checker dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .x           (x),
    .y           (y),
    .addr        (addr),
    .addr_valid  (addr_valid),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .err         (err),
    .locked      (locked),
    .frame_count (frame_count)
`ifdef RASTER_CHECKER_ERRCNT_EN
    ,
    .err_count   (err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: locked flag, next expected linear position, last address, counters.
  bit m_locked;
  int m_pos;
  int m_addr;
  int m_fc;
  int m_ec;
  bit e_av, e_fs, e_fd, e_err;

  wire [20:0] w_obs = {addr, addr_valid, frame_start, frame_done, err, locked, frame_count};

  function automatic logic [20:0] exp_vec();
    logic [7:0] a;
    logic [7:0] f;
    a = m_addr[7:0];
    f = m_fc[7:0];
    return {a, e_av, e_fs, e_fd, e_err, m_locked, f};
  endfunction

  task automatic model_reset();
    m_locked = 0; m_pos = 0; m_addr = 0; m_fc = 0; m_ec = 0;
    e_av = 0; e_fs = 0; e_fd = 0; e_err = 0;
  endtask

  task automatic model_step(input bit v, input int pos);
    e_av = 0; e_fs = 0; e_fd = 0; e_err = 0;
    if (v) begin
      if (!m_locked) begin
        if (pos == 0) begin
          m_locked = 1; m_pos = 1; m_addr = 0; e_av = 1; e_fs = 1;
        end
      end else if (pos == m_pos) begin
        m_addr = pos;
        e_av   = 1;
        m_pos  = (m_pos + 1) % 256;
        e_fs   = (pos == 0);
        if (pos == 255) begin
          e_fd = 1;
          m_fc = (m_fc + 1) % 256;
        end
      end else begin
        e_err    = 1;
        m_locked = 0;
        if (m_ec < 255) m_ec++;
      end
    end
  endtask

  // Present one sample for one clock; returns #1 after the capturing edge.
  task automatic drive(input bit v, input int pos);
    int p;
    p = pos;
    @(negedge clk);
    in_valid = v;
    x = p[3:0];
    y = p[7:4];
    model_step(v, pos);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(posedge clk); #1;
    checks++;
    if (w_obs !== 21'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h exp %h", w_obs, 21'd0);
    end
`ifdef RASTER_CHECKER_ERRCNT_EN
    checks++;
    if (err_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_err_count got %0d exp 0", err_count);
    end
`endif
  endtask

  task automatic test_full_frame();
    do_reset();
    for (int i = 0; i < 256; i++) begin
      drive(1, i);
      checks++;
      if (w_obs !== exp_vec()) begin
        errors++;
        $display("FAIL full_frame i=%0d got %h exp %h", i, w_obs, exp_vec());
      end
    end
    checks++;
    if (frame_count !== 8'd1 || locked !== 1'b1) begin
      errors++;
      $display("FAIL full_frame_end fc=%0d locked=%b exp fc=1 locked=1", frame_count, locked);
    end
  endtask

  task automatic test_late_start();
    do_reset();
    for (int i = 16 * 3 + 5; i <= 256; i++) begin
      drive(1, i % 256);
      checks++;
      if (w_obs !== exp_vec()) begin
        errors++;
        $display("FAIL late_start pos=%0d got %h exp %h", i % 256, w_obs, exp_vec());
      end
    end
    checks++;
    if (frame_start !== 1'b1 || addr !== 8'd0 || locked !== 1'b1) begin
      errors++;
      $display("FAIL late_start_lock fs=%b addr=%0d locked=%b exp 1 0 1", frame_start, addr, locked);
    end
  endtask

  task automatic test_mismatch();
    int p;
    do_reset();
    for (int i = 0; i < 36; i++) drive(1, i);
    drive(1, 2 * 16 + 6);
    checks++;
    if (err !== 1'b1 || locked !== 1'b0 || addr_valid !== 1'b0 || w_obs !== exp_vec()) begin
      errors++;
      $display("FAIL mismatch_err got %h exp %h", w_obs, exp_vec());
    end
    for (int i = 0; i < 12; i++) begin
      p = $urandom_range(255, 1);
      drive(1, p);
      checks++;
      if (w_obs !== exp_vec()) begin
        errors++;
        $display("FAIL mismatch_after i=%0d got %h exp %h", i, w_obs, exp_vec());
      end
    end
    drive(1, 0);
    checks++;
    if (w_obs !== exp_vec() || locked !== 1'b1) begin
      errors++;
      $display("FAIL mismatch_relock got %h exp %h", w_obs, exp_vec());
    end
`ifdef RASTER_CHECKER_ERRCNT_EN
    checks++;
    if (err_count !== 8'd1) begin
      errors++;
      $display("FAIL mismatch_err_count got %0d exp 1", err_count);
    end
`endif
  endtask

  task automatic test_gaps();
    do_reset();
    for (int i = 0; i <= 20; i++) drive(1, i);
    for (int i = 21; i < 40; i++) begin
      for (int g = 0; g < 3; g++) begin
        drive(0, $urandom_range(255, 0));
        checks++;
        if (w_obs !== exp_vec()) begin
          errors++;
          $display("FAIL gap pos=%0d g=%0d got %h exp %h", i, g, w_obs, exp_vec());
        end
      end
      drive(1, i);
      checks++;
      if (w_obs !== exp_vec()) begin
        errors++;
        $display("FAIL gap_resume pos=%0d got %h exp %h", i, w_obs, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    bit v;
    int p;
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      v = ($urandom_range(3, 0) != 0);
      if (m_locked) p = ($urandom_range(9, 0) != 0) ? m_pos : $urandom_range(255, 0);
      else          p = ($urandom_range(2, 0) == 0) ? 0 : $urandom_range(255, 0);
      drive(v, p);
      checks++;
      if (w_obs !== exp_vec()) begin
        errors++;
        $display("FAIL random i=%0d v=%0b pos=%0d got %h exp %h", i, v, p, w_obs, exp_vec());
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int f = 0; f < 256; f++) begin
      for (int i = 0; i < 256; i++) begin
        drive(1, i);
        checks++;
        if (w_obs !== exp_vec()) begin
          errors++;
          $display("FAIL wrap f=%0d i=%0d got %h exp %h", f, i, w_obs, exp_vec());
        end
      end
    end
    checks++;
    if (frame_count !== 8'd0) begin
      errors++;
      $display("FAIL wrap_count got %0d exp 0", frame_count);
    end
    // Alternate relock/mismatch across two frames' worth of samples to drive many errors.
    for (int i = 0; i < 512; i++) begin
      drive(1, (i % 2 == 0) ? 0 : $urandom_range(255, 2));
      checks++;
      if (w_obs !== exp_vec()) begin
        errors++;
        $display("FAIL err_burst i=%0d got %h exp %h", i, w_obs, exp_vec());
      end
    end
`ifdef RASTER_CHECKER_ERRCNT_EN
    checks++;
    if (err_count !== 8'd255) begin
      errors++;
      $display("FAIL err_count_sat got %0d exp 255", err_count);
    end
`endif
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i <= 9 * 16 + 7; i++) drive(1, i);
    #3;
    reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if (w_obs !== 21'd0) begin
      errors++;
      $display("FAIL async_reset got %h exp 0", w_obs);
    end
    @(posedge clk); #3;
    reset = 1'b1;
    for (int i = 9 * 16 + 8; i < 9 * 16 + 30; i++) begin
      drive(1, i);
      checks++;
      if (w_obs !== exp_vec() || locked !== 1'b0) begin
        errors++;
        $display("FAIL async_sync pos=%0d got %h exp %h", i, w_obs, exp_vec());
      end
    end
    drive(1, 0);
    checks++;
    if (w_obs !== exp_vec() || locked !== 1'b1 || frame_start !== 1'b1) begin
      errors++;
      $display("FAIL async_relock got %h exp %h", w_obs, exp_vec());
    end
  endtask

  initial begin
    reset = 1'b0;
    in_valid = 1'b0;
    x = 4'd0;
    y = 4'd0;
    model_reset();
    test_reset();
    test_full_frame();
    test_late_start();
    test_mismatch();
    test_gaps();
    test_random();
    test_async_reset();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
